// File: rtl/rect_fill_draw.sv
// rtl/rect_fill_draw.sv - multi-rectangle solid/outline/checker draw source for the shared frame-buffer write bus
module rect_fill_draw #(
    parameter int SOURCE_ID   = 0,
    parameter int SEL_WIDTH   = 4,
    parameter int COLOR_DEPTH = 9,
    parameter int NUM_RECTS   = 4,
    parameter int COORD_W     = 10,
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int CHECK_LOG2  = 3
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic                   start,
    input  logic [SEL_WIDTH-1:0]   write_source_sel,
    input  logic                   write_ready,
    input  logic                   cfg_we,
    input  logic [((NUM_RECTS > 1) ? $clog2(NUM_RECTS) : 1)-1:0] cfg_idx,
    input  logic [COORD_W-1:0]     cfg_x,
    input  logic [COORD_W-1:0]     cfg_y,
    input  logic [COORD_W-1:0]     cfg_w,
    input  logic [COORD_W-1:0]     cfg_h,
    input  logic [COLOR_DEPTH-1:0] cfg_color,
    input  logic [1:0]             cfg_mode,
    input  logic                   cfg_en,
    output logic [31:0]            write_x_addr,
    output logic [31:0]            write_y_addr,
    output logic [COLOR_DEPTH-1:0] write_color_data,
    output logic                   write_transparent,
    output logic                   write_active,
    output logic                   busy,
    output logic                   done
);
    localparam int IDX_W = (NUM_RECTS > 1) ? $clog2(NUM_RECTS) : 1;
    localparam int NRW   = IDX_W + 1;
    localparam int CW1   = COORD_W + 1;
    localparam logic [CW1-1:0]       SCR_W  = CW1'(SCREEN_W);
    localparam logic [CW1-1:0]       SCR_H  = CW1'(SCREEN_H);
    localparam logic [NRW-1:0]       NR     = NRW'(NUM_RECTS);
    localparam logic [IDX_W-1:0]     LAST_R = IDX_W'(NUM_RECTS - 1);
    localparam logic [SEL_WIDTH-1:0] OWN_ID = SEL_WIDTH'(SOURCE_ID);

    typedef enum logic [2:0] {S_IDLE, S_LATCH, S_SETUP, S_DRAW, S_DONE} state_t;

    state_t state_q, state_d;

    logic [COORD_W-1:0]     cx_q [NUM_RECTS];
    logic [COORD_W-1:0]     cy_q [NUM_RECTS];
    logic [COORD_W-1:0]     cw_q [NUM_RECTS];
    logic [COORD_W-1:0]     ch_q [NUM_RECTS];
    logic [COLOR_DEPTH-1:0] ccol_q [NUM_RECTS];
    logic [1:0]             cmode_q [NUM_RECTS];
    logic                   cen_q [NUM_RECTS];

    logic [COORD_W-1:0]     wx_q [NUM_RECTS];
    logic [COORD_W-1:0]     wy_q [NUM_RECTS];
    logic [COORD_W-1:0]     ww_q [NUM_RECTS];
    logic [COORD_W-1:0]     wh_q [NUM_RECTS];
    logic [COLOR_DEPTH-1:0] wcol_q [NUM_RECTS];
    logic [1:0]             wmode_q [NUM_RECTS];
    logic                   wen_q [NUM_RECTS];

    logic [IDX_W-1:0] r_q, r_d;
    logic [CW1-1:0]   x_q, x_d, y_q, y_d, xe_q, xe_d, ye_q, ye_d;

    logic [CW1-1:0] cur_x0, cur_y0, cur_w, cur_h, sum_x, sum_y, xe_c, ye_c;
    logic [CW1-1:0] right_c, bottom_c, dx, dy;
    logic           skip, last, owner, adv;

    // Host-side slots: writable at any time, only sampled into the working copy at LATCH
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < NUM_RECTS; i++) begin
                cx_q[i] <= '0; cy_q[i] <= '0; cw_q[i] <= '0; ch_q[i] <= '0;
                ccol_q[i] <= '0; cmode_q[i] <= '0; cen_q[i] <= 1'b0;
            end
        end else if (cfg_we && ({1'b0, cfg_idx} < NR)) begin
            cx_q[cfg_idx]    <= cfg_x;
            cy_q[cfg_idx]    <= cfg_y;
            cw_q[cfg_idx]    <= cfg_w;
            ch_q[cfg_idx]    <= cfg_h;
            ccol_q[cfg_idx]  <= cfg_color;
            cmode_q[cfg_idx] <= cfg_mode;
            cen_q[cfg_idx]   <= cfg_en;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < NUM_RECTS; i++) begin
                wx_q[i] <= '0; wy_q[i] <= '0; ww_q[i] <= '0; wh_q[i] <= '0;
                wcol_q[i] <= '0; wmode_q[i] <= '0; wen_q[i] <= 1'b0;
            end
        end else if (state_q == S_LATCH) begin
            for (int i = 0; i < NUM_RECTS; i++) begin
                wx_q[i] <= cx_q[i]; wy_q[i] <= cy_q[i]; ww_q[i] <= cw_q[i]; wh_q[i] <= ch_q[i];
                wcol_q[i] <= ccol_q[i]; wmode_q[i] <= cmode_q[i]; wen_q[i] <= cen_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= S_IDLE;
            r_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            xe_q    <= '0;
            ye_q    <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            x_q     <= x_d;
            y_q     <= y_d;
            xe_q    <= xe_d;
            ye_q    <= ye_d;
        end
    end

    // Geometry of the slot under the current index, one bit wider so sums cannot wrap
    always_comb begin
        cur_x0   = {1'b0, wx_q[r_q]};
        cur_y0   = {1'b0, wy_q[r_q]};
        cur_w    = {1'b0, ww_q[r_q]};
        cur_h    = {1'b0, wh_q[r_q]};
        sum_x    = cur_x0 + cur_w;
        sum_y    = cur_y0 + cur_h;
        xe_c     = (sum_x > SCR_W) ? SCR_W : sum_x;
        ye_c     = (sum_y > SCR_H) ? SCR_H : sum_y;
        right_c  = sum_x - CW1'(1);
        bottom_c = sum_y - CW1'(1);
        dx       = x_q - cur_x0;
        dy       = y_q - cur_y0;
        skip     = !wen_q[r_q] || (cur_w == '0) || (cur_h == '0) ||
                   (cur_x0 >= SCR_W) || (cur_y0 >= SCR_H);
        last     = (r_q == LAST_R);
        owner    = (write_source_sel == OWN_ID);
        adv      = (state_q == S_DRAW) && owner && write_ready;
    end

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        x_d     = x_q;
        y_d     = y_q;
        xe_d    = xe_q;
        ye_d    = ye_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_LATCH;
            S_LATCH: begin
                state_d = S_SETUP;
                r_d     = '0;
            end
            S_SETUP: begin
                if (skip) begin
                    if (last) state_d = S_DONE;
                    else      r_d     = r_q + IDX_W'(1);
                end else begin
                    x_d     = cur_x0;
                    y_d     = cur_y0;
                    xe_d    = xe_c;
                    ye_d    = ye_c;
                    state_d = S_DRAW;
                end
            end
            S_DRAW: begin
                if (adv) begin
                    if (x_q + CW1'(1) == xe_q) begin
                        x_d = cur_x0;
                        if (y_q + CW1'(1) == ye_q) begin
                            if (last) begin
                                state_d = S_DONE;
                            end else begin
                                r_d     = r_q + IDX_W'(1);
                                state_d = S_SETUP;
                            end
                        end else begin
                            y_d = y_q + CW1'(1);
                        end
                    end else begin
                        x_d = x_q + CW1'(1);
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Bus outputs are forced to zero when not presenting so sources can be OR-combined
    always_comb begin
        busy              = (state_q != S_IDLE);
        done              = (state_q == S_DONE);
        write_active      = (state_q == S_DRAW) && owner;
        write_x_addr      = '0;
        write_y_addr      = '0;
        write_color_data  = '0;
        write_transparent = 1'b0;
        if (write_active) begin
            write_x_addr     = 32'(x_q);
            write_y_addr     = 32'(y_q);
            write_color_data = wcol_q[r_q];
            case (wmode_q[r_q])
                2'd1:    write_transparent = !((x_q == cur_x0) || (x_q == right_c) ||
                                               (y_q == cur_y0) || (y_q == bottom_c));
                2'd2:    write_transparent = dx[CHECK_LOG2] ^ dy[CHECK_LOG2];
                default: write_transparent = 1'b0;
            endcase
        end
    end
endmodule
